// File: rtl/mem_port_pkg.sv
// Shared command encodings and state type for the memory access stage.
// The MEM_* and ADDR_FROM_* values must stay identical to the decoder's encodings.
package mem_port_pkg;

  localparam logic [1:0] MEM_PAUSE = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic ADDR_FROM_PC = 1'b0;
  localparam logic ADDR_FROM_AR = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Code 2'b11 is deliberately not an access; it behaves as a pause.
  function automatic logic is_access(input logic [1:0] action);
    return (action == MEM_READ) || (action == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_pc_reg.sv
// Program counter: load has priority over increment; increment wraps naturally.
module pc_reg #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_load_i,
  input  logic [ADDR_WIDTH-1:0] pc_value_i,
  input  logic                  pc_inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (pc_load_i) begin
      pc_d = pc_value_i;
    end else if (pc_inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mem_port.sv
// Memory access stage: turns the decoder's per-cycle memory command into a
// registered req/ack bus transaction with timeout abort, and owns the PC.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_mem_action,
  input  logic                  i_mem_addr_source,
  input  logic                  i_pc_counter_en,
  input  logic [ADDR_WIDTH-1:0] i_ar,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pc_load,
  input  logic [ADDR_WIDTH-1:0] i_pc_value,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic                  o_bus_err,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

  // Abort fires on the REQ edge where the counter already holds TIMEOUT-1,
  // so req stays high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cnt_en_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  bus_err_q;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_inc;

  assign pc_inc = (state_q == ST_REQ) && i_bus_ack && cnt_en_q;

  pc_reg #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_load_i  (i_pc_load),
    .pc_value_i (i_pc_value),
    .pc_inc_i   (pc_inc),
    .pc_o       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      cnt_en_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_access(i_mem_action)) begin
            addr_q   <= (i_mem_addr_source == ADDR_FROM_PC) ? pc : i_ar;
            we_q     <= (i_mem_action == MEM_WRITE);
            wdata_q  <= i_wdata;
            // Only sequential instruction fetches advance the PC.
            cnt_en_q <= (i_mem_action == MEM_READ) &&
                        (i_mem_addr_source == ADDR_FROM_PC) && i_pc_counter_en;
            cnt_q    <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_bus_ack) begin
            state_q <= ST_IDLE;
            if (!we_q) begin
              rdata_q       <= i_bus_rdata;
              rdata_valid_q <= 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_pc          = pc;
  assign o_busy        = (state_q == ST_REQ);
  assign o_bus_req     = (state_q == ST_REQ);
  assign o_bus_we      = we_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: stimulus pushes expected requests and
// completions; a negedge monitor pops and compares as the bus shows them.
module tb_mem_port;
  import mem_port_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] i_mem_action = MEM_PAUSE;
  logic       i_mem_addr_source = 1'b0;
  logic       i_pc_counter_en = 1'b0;
  logic [7:0] i_ar = '0;
  logic [7:0] i_wdata = '0;
  logic       i_pc_load = 1'b0;
  logic [7:0] i_pc_value = '0;
  logic [7:0] o_pc;
  logic       o_busy;
  logic [7:0] o_rdata;
  logic       o_rdata_valid;
  logic       o_bus_err;
  logic       o_bus_req;
  logic       o_bus_we;
  logic [7:0] o_bus_addr;
  logic [7:0] o_bus_wdata;
  logic       i_bus_ack = 1'b0;
  logic [7:0] i_bus_rdata = '0;

  mem_port #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_action(i_mem_action), .i_mem_addr_source(i_mem_addr_source),
    .i_pc_counter_en(i_pc_counter_en), .i_ar(i_ar), .i_wdata(i_wdata),
    .i_pc_load(i_pc_load), .i_pc_value(i_pc_value),
    .o_pc(o_pc), .o_busy(o_busy), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_bus_err(o_bus_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } req_t;

  typedef struct {
    logic       valid;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] pc;
    int         len;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per completed transaction.
  initial begin : monitor
    req_t cur;
    rsp_t exp;
    bit   in_req = 0;
    int   req_len = 0;
    cur = '{addr: '0, we: 1'b0, wdata: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_req = 0;
        req_len = 0;
        continue;
      end
      if (o_bus_req && !in_req) begin
        n_req++;
        in_req = 1;
        req_len = 0;
        total++;
        if (req_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_req: got addr %0h expected no request", o_bus_addr);
          cur = '{addr: o_bus_addr, we: o_bus_we, wdata: o_bus_wdata};
        end else begin
          cur = req_q.pop_front();
        end
      end
      if (o_bus_req) begin
        req_len++;
        chk("bus_addr", 32'(o_bus_addr), 32'(cur.addr));
        chk("bus_we", 32'(o_bus_we), 32'(cur.we));
        if (cur.we) chk("bus_wdata", 32'(o_bus_wdata), 32'(cur.wdata));
        chk("busy_in_req", 32'(o_busy), 32'd1);
      end else if (in_req) begin
        in_req = 0;
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_completion: got completion expected none");
        end else begin
          exp = rsp_q.pop_front();
          chk("rdata_valid", 32'(o_rdata_valid), 32'(exp.valid));
          chk("bus_err", 32'(o_bus_err), 32'(exp.err));
          chk("rdata", 32'(o_rdata), 32'(exp.rdata));
          chk("pc_after", 32'(o_pc), 32'(exp.pc));
          chk("req_len", 32'(req_len), 32'(exp.len));
          chk("busy_after", 32'(o_busy), 32'd0);
          $display("txn addr=%0h we=%0b len=%0d valid=%0b err=%0b rdata=%0h pc=%0h",
                   cur.addr, cur.we, req_len, o_rdata_valid, o_bus_err, o_rdata, o_pc);
        end
      end else begin
        chk("no_stray_pulse", {30'd0, o_rdata_valid, o_bus_err}, 32'd0);
      end
    end
  end

  task automatic load_pc(input logic [7:0] v);
    i_pc_load = 1'b1;
    i_pc_value = v;
    tick();
    i_pc_load = 1'b0;
    chk("pc_load", 32'(o_pc), 32'(v));
  endtask

  // waits < 0 means memory never acknowledges.
  task automatic issue(input logic [1:0] action, input logic src, input logic cnt,
                       input logic [7:0] ar, input logic [7:0] wd, input int waits,
                       input logic [7:0] rd, input bit load_at_ack, input logic [7:0] load_val,
                       input bit junk);
    i_mem_action = action;
    i_mem_addr_source = src;
    i_pc_counter_en = cnt;
    i_ar = ar;
    i_wdata = wd;
    tick();
    i_mem_action = MEM_PAUSE;
    i_pc_counter_en = 1'b0;
    if (junk) begin
      i_mem_action = MEM_READ;
      i_mem_addr_source = ADDR_FROM_AR;
      i_ar = 8'h77;
    end
    if (waits < 0) begin
      repeat (TO + 2) tick();
    end else begin
      repeat (waits) tick();
      i_bus_ack = 1'b1;
      i_bus_rdata = rd;
      if (load_at_ack) begin
        i_pc_load = 1'b1;
        i_pc_value = load_val;
      end
      tick();
      i_bus_ack = 1'b0;
      i_pc_load = 1'b0;
      i_mem_action = MEM_PAUSE;
      tick();
      tick();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(o_bus_req), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);
    chk("rst_pulses", {30'd0, o_rdata_valid, o_bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait counted fetch from PC
    load_pc(8'h10);
    req_q.push_back('{addr: 8'h10, we: 1'b0, wdata: 8'h00});
    rsp_q.push_back('{valid: 1'b1, err: 1'b0, rdata: 8'hA5, pc: 8'h11, len: 1});
    issue(MEM_READ, ADDR_FROM_PC, 1'b1, 8'h00, 8'h00, 0, 8'hA5, 0, 8'h00, 0);

    // Write via AR, ack lands on the same edge as the timeout would
    req_q.push_back('{addr: 8'h40, we: 1'b1, wdata: 8'h3C});
    rsp_q.push_back('{valid: 1'b0, err: 1'b0, rdata: 8'hA5, pc: 8'h11, len: 4});
    issue(MEM_WRITE, ADDR_FROM_AR, 1'b0, 8'h40, 8'h3C, 3, 8'hEE, 0, 8'h00, 0);

    // Never acknowledged: abort after TO cycles, rdata held
    req_q.push_back('{addr: 8'h22, we: 1'b0, wdata: 8'h00});
    rsp_q.push_back('{valid: 1'b0, err: 1'b1, rdata: 8'hA5, pc: 8'h11, len: TO});
    issue(MEM_READ, ADDR_FROM_AR, 1'b0, 8'h22, 8'h00, -1, 8'h00, 0, 8'h00, 0);

    // PC wrap
    load_pc(8'hFF);
    req_q.push_back('{addr: 8'hFF, we: 1'b0, wdata: 8'h00});
    rsp_q.push_back('{valid: 1'b1, err: 1'b0, rdata: 8'h5A, pc: 8'h00, len: 2});
    issue(MEM_READ, ADDR_FROM_PC, 1'b1, 8'h00, 8'h00, 1, 8'h5A, 0, 8'h00, 0);

    // Load beats same-edge increment
    load_pc(8'hFF);
    req_q.push_back('{addr: 8'hFF, we: 1'b0, wdata: 8'h00});
    rsp_q.push_back('{valid: 1'b1, err: 1'b0, rdata: 8'hC3, pc: 8'h80, len: 1});
    issue(MEM_READ, ADDR_FROM_PC, 1'b1, 8'h00, 8'h00, 0, 8'hC3, 1, 8'h80, 0);

    // AR-sourced read ignores count enable; commands during REQ ignored
    req_q.push_back('{addr: 8'h30, we: 1'b0, wdata: 8'h00});
    rsp_q.push_back('{valid: 1'b1, err: 1'b0, rdata: 8'h11, pc: 8'h80, len: 3});
    issue(MEM_READ, ADDR_FROM_AR, 1'b1, 8'h30, 8'h00, 2, 8'h11, 0, 8'h00, 1);

    // Write from PC with count enable: no increment
    req_q.push_back('{addr: 8'h80, we: 1'b1, wdata: 8'h99});
    rsp_q.push_back('{valid: 1'b0, err: 1'b0, rdata: 8'h11, pc: 8'h80, len: 1});
    issue(MEM_WRITE, ADDR_FROM_PC, 1'b1, 8'h00, 8'h99, 0, 8'h00, 0, 8'h00, 0);

    // Asynchronous reset in the middle of a request
    load_pc(8'h55);
    req_q.push_back('{addr: 8'h55, we: 1'b0, wdata: 8'h00});
    i_mem_action = MEM_READ;
    i_mem_addr_source = ADDR_FROM_PC;
    i_pc_counter_en = 1'b1;
    tick();
    i_mem_action = MEM_PAUSE;
    i_pc_counter_en = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(o_bus_req), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_pc", 32'(o_pc), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_bus_ack = 1'b1;
    i_bus_rdata = 8'hEE;
    tick();
    i_bus_ack = 1'b0;
    tick();
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_req", 32'(o_bus_req), 32'd0);
    chk("post_rst_rdata", 32'(o_rdata), 32'd0);
    chk("post_rst_pc", 32'(o_pc), 32'd0);

    tick();
    chk("req_count", 32'(n_req), 32'd8);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port.md
# mem_port

Memory access stage directly downstream of the instruction decoder. Converts the decoder's per-cycle memory command (`mem_action`, address source, PC-count enable) into a registered request/acknowledge transaction on the external memory bus. Owns the program counter, returns read data with a one-cycle valid strobe, and raises busy while a transaction is outstanding so the core holds its command.

## Interface
- `DATA_WIDTH`, 8, data bus width (matches the core `DATA_WIDTH`)
- `ADDR_WIDTH`, 8, memory address width, also PC width
- `TIMEOUT`, 15, max cycles a request waits for ack before abort (≥1, ≤255)

- `clk` in 1 core clock, rising edge
- `rst_n` in 1 reset, asynchronous, active-low
- `i_mem_action` in 2 command: `MEM_PAUSE`=00, `MEM_READ`=01, `MEM_WRITE`=10; 11 is treated as pause
- `i_mem_addr_source` in 1 `ADDR_FROM_PC`=0, `ADDR_FROM_AR`=1
- `i_pc_counter_en` in 1 increment PC when this read completes
- `i_ar` in ADDR_WIDTH address register value
- `i_wdata` in DATA_WIDTH write data from the unit output bus
- `i_pc_load` in 1 load PC from `i_pc_value`
- `i_pc_value` in ADDR_WIDTH PC load value
- `o_pc` out ADDR_WIDTH current PC
- `o_busy` out 1 transaction outstanding; new commands ignored
- `o_rdata` out DATA_WIDTH last read data, held until next read completes
- `o_rdata_valid` out 1 one-cycle pulse when `o_rdata` updates
- `o_bus_err` out 1 one-cycle pulse on timeout abort
- `o_bus_req` out 1 request to memory
- `o_bus_we` out 1 1=write, 0=read; valid while `o_bus_req`
- `o_bus_addr` out ADDR_WIDTH request address
- `o_bus_wdata` out DATA_WIDTH write data
- `i_bus_ack` in 1 memory acknowledge
- `i_bus_rdata` in DATA_WIDTH read data, valid with `i_bus_ack`

## Operation
- States: IDLE, REQ. All outputs reset to 0; state to IDLE; timeout counter to 0.
- IDLE: when `i_mem_action` is READ or WRITE, latch address (`o_pc` if source=PC else `i_ar`), `we`, `i_wdata`, `i_pc_counter_en` (qualified: only for READ with source=PC); go to REQ, clear counter. PAUSE/11: stay IDLE, no bus activity.
- REQ: `o_bus_req`=1, `o_busy`=1, bus fields stable from latched values. On `i_bus_ack`: drop req, go IDLE; for read register `i_bus_rdata` into `o_rdata` and pulse `o_rdata_valid`; if latched count-enable, PC increments by 1.
- Timeout: counter increments each REQ cycle without ack; when it reaches `TIMEOUT` without ack, drop req, go IDLE, pulse `o_bus_err`, no rdata update, no PC increment.
- Commands presented while REQ are ignored (decoder must hold or re-issue).
- `i_bus_ack` while not in REQ is ignored.
- PC: wraps from 2^ADDR_WIDTH−1 to 0. `i_pc_load` takes priority over a same-cycle increment. PC load may occur in any state; an already-latched address is unaffected.

## Timing
- Command sampled at edge N (IDLE) → `o_bus_req` high from N+1.
- Ack sampled at edge M while in REQ → from M+1: req low, `o_busy` low, `o_rdata_valid` high for one cycle, new PC visible.
- Zero-wait memory (ack in first REQ cycle): command at N, data/PC at N+2; next command accepted at N+2.
- Ack and timeout on the same edge: ack wins.
- Asynchronous reset mid-transaction: req, busy, valid, err drop immediately; PC to 0; transaction abandoned.
- `o_busy` = (state==REQ), registered; no combinational path from `i_mem_action` to any output.

## Structure
- `MEM_*` action codes and `ADDR_FROM_*` constants live in the shared `define.v`, same values the decoder uses; no local redefinition.
- One sub-module natural: `pc_reg` (load/increment/wrap PC register). FSM, latches and timeout counter in `mem_port` top.

## Test plan
- Zero-wait read from PC: PC=0x10, action=READ, source=PC, count_en=1, ack first cycle with rdata=0xA5 → bus_addr=0x10, we=0, rdata=0xA5 valid at N+2, PC=0x11.
- Write via AR with 3 wait cycles: AR=0x40, wdata=0x3C → req held 4 cycles, addr=0x40, we=1, wdata=0x3C, no rdata_valid, PC unchanged.
- Timeout: TIMEOUT=4, never ack → req high exactly 4 cycles, bus_err one-cycle pulse, busy low after, PC unchanged.
- PC wrap and load priority: PC=0xFF count read completes → PC=0x00; repeat with i_pc_load=1, value=0x80 same edge → PC=0x80.
- Busy ignore: second READ issued during REQ with different AR → only first address appears on bus; one rdata_valid.
- Reset mid-REQ: assert rst_n low between edges → req/busy/PC zero immediately; after release, IDLE with no stale ack effect.
